// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared state codes and widths for the I2C slave controller.
// Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

  localparam int STATE_W = 5;
  localparam int DATA_W  = 8;

  localparam logic [STATE_W-1:0] ST_IDLE          = 5'd0;
  localparam logic [STATE_W-1:0] ST_START         = 5'd1;
  localparam logic [STATE_W-1:0] ST_DEVICE_ADDR   = 5'd2;
  localparam logic [STATE_W-1:0] ST_READ_OR_WRITE = 5'd3;
  localparam logic [STATE_W-1:0] ST_ADDR_ACK      = 5'd4;
  localparam logic [STATE_W-1:0] ST_REG_ADDR      = 5'd5;
  localparam logic [STATE_W-1:0] ST_REG_ACK       = 5'd6;
  localparam logic [STATE_W-1:0] ST_WRITE         = 5'd7;
  localparam logic [STATE_W-1:0] ST_WRITE_ACK     = 5'd8;
  localparam logic [STATE_W-1:0] ST_READ          = 5'd9;
  localparam logic [STATE_W-1:0] ST_READ_ACK      = 5'd10;
  localparam logic [STATE_W-1:0] ST_STOP          = 5'd11;

endpackage
`default_nettype wire

// File: rtl/i2c_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : i2c_edge_detect
// Brief    : SCL/SDA synchronisers with SCL edge and START/STOP pulse outputs.
// Revision : 1.0  initial release
// ============================================================================
module i2c_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Everything freezes with ena so re-enabling cannot fabricate an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else if (i_ena) begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  // START/STOP need SCL high on both samples, so they never coincide with an SCL edge.
  assign o_sda      = w_sda;
  assign o_scl_rise = i_ena & w_scl & ~r_scl_prev;
  assign o_scl_fall = i_ena & ~w_scl & r_scl_prev;
  assign o_start    = i_ena & w_scl & r_scl_prev & ~w_sda & r_sda_prev;
  assign o_stop     = i_ena & w_scl & r_scl_prev & w_sda & ~r_sda_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_fsm
// Brief    : I2C slave protocol FSM with register pointer, write strobe and
//            single-byte read fetch.
// Revision : 1.0  initial release
// ============================================================================
module i2c_slave_fsm
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               SCL_in,
  input  logic               SDA_in,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         data_index,
  output logic [DATA_W-1:0]  read_value,
  output logic [DATA_W-1:0]  reg_addr,
  input  logic [DATA_W-1:0]  reg_rd_data,
  output logic [DATA_W-1:0]  reg_wr_data,
  output logic               reg_wr_en,
  output logic               busy
);

  logic               w_sda;
  logic               w_rise;
  logic               w_fall;
  logic               w_start;
  logic               w_stop;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [2:0]         r_idx;
  logic [6:0]         r_dev_addr;
  logic               r_rw;
  logic [DATA_W-1:0]  r_reg_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [DATA_W-1:0]  r_rd_val;
  logic               r_wr_en;
  logic               w_busy;

  i2c_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ena      (ena),
    .i_scl      (SCL_in),
    .i_sda      (SDA_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_START;
    end else begin
      case (r_state)
        ST_IDLE:          w_state_nxt = ST_IDLE;
        ST_START:         if (w_fall) w_state_nxt = ST_DEVICE_ADDR;
        ST_DEVICE_ADDR:   if (w_rise && r_idx == 3'd0) w_state_nxt = ST_READ_OR_WRITE;
        ST_READ_OR_WRITE: if (w_rise) w_state_nxt = (r_dev_addr == DEVICE_ADDR) ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK:      if (w_rise) w_state_nxt = r_rw ? ST_READ : ST_REG_ADDR;
        ST_REG_ADDR:      if (w_rise && r_idx == 3'd0) w_state_nxt = ST_REG_ACK;
        ST_REG_ACK:       if (w_rise) w_state_nxt = ST_WRITE;
        ST_WRITE:         if (w_rise && r_idx == 3'd0) w_state_nxt = ST_WRITE_ACK;
        ST_WRITE_ACK:     if (w_rise) w_state_nxt = ST_WRITE;
        ST_READ:          if (w_rise && r_idx == 3'd0) w_state_nxt = ST_READ_ACK;
        ST_READ_ACK:      if (w_rise) w_state_nxt = ST_STOP;
        ST_STOP:          w_state_nxt = ST_STOP;
        default:          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Bit index wraps 0->7 at the end of every byte, ready for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 3'd7;
      r_dev_addr <= '0;
      r_rw       <= 1'b0;
      r_reg_addr <= '0;
      r_wr_data  <= '0;
      r_rd_val   <= '0;
      r_wr_en    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_stop || w_start) begin
        r_idx <= 3'd7;
      end else begin
        case (r_state)
          ST_START: if (w_fall) r_idx <= 3'd6;
          ST_DEVICE_ADDR: if (w_rise) begin
            r_dev_addr <= {r_dev_addr[5:0], w_sda};
            r_idx      <= r_idx - 3'd1;
          end
          ST_READ_OR_WRITE: if (w_rise) r_rw <= w_sda;
          ST_ADDR_ACK: if (w_rise && r_rw) begin
            r_rd_val <= reg_rd_data;
            r_idx    <= 3'd7;
          end
          ST_REG_ADDR: if (w_rise) begin
            r_reg_addr <= {r_reg_addr[DATA_W-2:0], w_sda};
            r_idx      <= r_idx - 3'd1;
          end
          ST_REG_ACK: if (w_rise) r_idx <= 3'd7;
          ST_WRITE: if (w_rise) begin
            r_wr_data <= {r_wr_data[DATA_W-2:0], w_sda};
            r_idx     <= r_idx - 3'd1;
            r_wr_en   <= (r_idx == 3'd0);
          end
          ST_WRITE_ACK: if (w_rise) begin
            r_reg_addr <= r_reg_addr + 8'd1;
            r_idx      <= 3'd7;
          end
          ST_READ: if (w_rise) r_idx <= r_idx - 3'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_busy = (r_state != ST_IDLE);
  end

  assign state       = r_state;
  assign data_index  = r_idx;
  assign read_value  = r_rd_val;
  assign reg_addr    = r_reg_addr;
  assign reg_wr_data = r_wr_data;
  assign reg_wr_en   = r_wr_en;
  assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_fsm
// Brief    : Self-checking bench for i2c_slave_fsm driving bit-level I2C traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave_fsm;

  localparam int Q = 4;
  localparam int H = 8;
  localparam logic [4:0] T_IDLE = 5'd0,  T_DEV = 5'd2,  T_AACK = 5'd4, T_REG = 5'd5;
  localparam logic [4:0] T_RACK = 5'd6,  T_WR = 5'd7,   T_RD = 5'd9,   T_RDACK = 5'd10;
  localparam logic [4:0] T_STOP = 5'd11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic [4:0] state;
  logic [2:0] data_index;
  logic [7:0] read_value;
  logic [7:0] reg_addr;
  logic [7:0] reg_rd_data;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       busy;

  logic [7:0]  mem [256];
  logic [15:0] wr_log [$];
  logic [15:0] exp_q [$];
  int          state_cnt [32];
  int          wr_rd = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign reg_rd_data = mem[reg_addr];

  i2c_slave_fsm #(.DEVICE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .SCL_in(scl), .SDA_in(sda),
    .state(state), .data_index(data_index), .read_value(read_value),
    .reg_addr(reg_addr), .reg_rd_data(reg_rd_data), .reg_wr_data(reg_wr_data),
    .reg_wr_en(reg_wr_en), .busy(busy)
  );

  always @(negedge clk) begin
    if (rst_n && reg_wr_en) wr_log.push_back({reg_addr, reg_wr_data});
    state_cnt[state] <= state_cnt[state] + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sda = b;   wait_clk(Q);
    scl = 1'b1; wait_clk(H);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(ack);
  endtask

  task automatic bus_start;
    sda = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    sda = 1'b0; wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop;
    sda = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    sda = 1'b1; wait_clk(Q);
  endtask

  task automatic check_writes(input string nm);
    int n_got;
    n_got = wr_log.size() - wr_rd;
    chk({nm, " wr_count"}, 32'(n_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_got; i++)
      chk({nm, " wr_addr_data"}, 32'(wr_log[wr_rd + i]), 32'(exp_q[i]));
    wr_rd = wr_log.size();
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0]  addr_byte;
    int          nbytes;
    logic [7:0]  b [3];
    logic        exp_aack;
    logic        exp_rack;
    int          exp_nwr;
    logic [15:0] w [2];
  } vec_t;

  vec_t       vecs [3];
  int         s_aack, s_rack, kind, n;
  logic [7:0] model_ptr;
  logic [7:0] rb [3];
  logic [6:0] dev;

  initial begin
    vecs[0] = '{addr_byte: 8'h54, nbytes: 2, b: '{8'h10, 8'h5C, 8'h00},
                exp_aack: 1'b1, exp_rack: 1'b1, exp_nwr: 1, w: '{16'h105C, 16'h0000}};
    vecs[1] = '{addr_byte: 8'h54, nbytes: 3, b: '{8'hFF, 8'h11, 8'h22},
                exp_aack: 1'b1, exp_rack: 1'b1, exp_nwr: 2, w: '{16'hFF11, 16'h0022}};
    vecs[2] = '{addr_byte: 8'h56, nbytes: 2, b: '{8'h10, 8'h77, 8'h00},
                exp_aack: 1'b0, exp_rack: 1'b0, exp_nwr: 0, w: '{16'h0000, 16'h0000}};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[3] = 8'hA5;

    // reset values
    #1 rst_n = 1'b0;
    wait_clk(3);
    chk("reset state", 32'(state), 32'(T_IDLE));
    chk("reset data_index", 32'(data_index), 32'd7);
    chk("reset others", 32'({read_value, reg_addr, reg_wr_data, reg_wr_en, busy}), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // directed write / burst / wrong address transactions
    for (int v = 0; v < 3; v++) begin
      s_aack = state_cnt[T_AACK];
      s_rack = state_cnt[T_RACK];
      bus_start;
      send_byte(vecs[v].addr_byte, 1'b0);
      for (int k = 0; k < vecs[v].nbytes; k++) send_byte(vecs[v].b[k], 1'b0);
      bus_stop;
      wait_clk(4);
      chk($sformatf("vec%0d addr_ack_seen", v), 32'(state_cnt[T_AACK] != s_aack), 32'(vecs[v].exp_aack));
      chk($sformatf("vec%0d reg_ack_seen", v), 32'(state_cnt[T_RACK] != s_rack), 32'(vecs[v].exp_rack));
      for (int k = 0; k < vecs[v].exp_nwr; k++) exp_q.push_back(vecs[v].w[k]);
      check_writes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d end state", v), 32'(state), 32'(T_IDLE));
      chk($sformatf("vec%0d busy", v), 32'(busy), 32'd0);
    end

    // pointer write, repeated START, single-byte read
    bus_start;
    send_byte(8'h54, 1'b0);
    send_byte(8'h03, 1'b0);
    chk("rd pre state", 32'(state), 32'(T_WR));
    bus_start;
    send_byte(8'h55, 1'b0);
    chk("rd entry state", 32'(state), 32'(T_RD));
    chk("rd value", 32'(read_value), 32'h A5);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd index bit%0d", i), 32'(data_index), 32'(7 - i));
      send_bit(1'b1);
    end
    chk("rd value held", 32'(read_value), 32'hA5);
    chk("rd ack state", 32'(state), 32'(T_RDACK));
    send_bit(1'b1);
    chk("rd stop state", 32'(state), 32'(T_STOP));
    bus_stop;
    wait_clk(2);
    chk("rd idle", 32'(state), 32'(T_IDLE));
    check_writes("rd");

    // STOP after 4 data bits: no strobe
    bus_start;
    send_byte(8'h54, 1'b0);
    send_byte(8'h20, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop;
    wait_clk(2);
    chk("partial idle", 32'(state), 32'(T_IDLE));
    check_writes("partial");

    // async reset in the middle of the register pointer byte
    bus_start;
    send_byte(8'h54, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("arst pre state", 32'(state), 32'(T_REG));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst state", 32'(state), 32'(T_IDLE));
    chk("arst data_index", 32'(data_index), 32'd7);
    chk("arst others", 32'({read_value, reg_addr, reg_wr_data, reg_wr_en, busy}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bus_stop;
    wait_clk(2);
    check_writes("arst");

    // ena low for 20 clk mid address byte while SCL toggles
    bus_start;
    for (int i = 7; i >= 5; i--) send_bit(1'(8'h54 >> i));
    chk("ena pre", 32'({state, data_index}), 32'({T_DEV, 3'd3}));
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      scl = ~scl;
      wait_clk(2);
      chk($sformatf("ena hold %0d", i), 32'({state, data_index}), 32'({T_DEV, 3'd3}));
    end
    ena = 1'b1;
    wait_clk(6);
    chk("ena resume", 32'({state, data_index}), 32'({T_DEV, 3'd3}));
    for (int i = 4; i >= 0; i--) send_bit(1'(8'h54 >> i));
    send_bit(1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h66, 1'b0);
    bus_stop;
    wait_clk(2);
    exp_q.push_back(16'h3066);
    check_writes("ena");

    // randomized transactions against a transaction-level model
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    model_ptr = 8'h00;
    wr_rd = wr_log.size();
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        bus_start;
        send_byte(8'h55, 1'b0);
        chk("rnd rd state", 32'(state), 32'(T_RD));
        chk("rnd rd value", 32'(read_value), 32'(mem[model_ptr]));
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        bus_stop;
      end else begin
        dev = 7'h2A;
        if (kind == 1) begin
          dev = 7'($urandom_range(0, 127));
          if (dev == 7'h2A) dev = 7'h2B;
        end
        n = $urandom_range(1, 3);
        for (int k = 0; k < 3; k++) rb[k] = 8'($urandom);
        bus_start;
        send_byte({dev, 1'b0}, 1'b0);
        for (int k = 0; k < n; k++) send_byte(rb[k], 1'b0);
        bus_stop;
        if (dev == 7'h2A) begin
          model_ptr = rb[0];
          for (int k = 1; k < n; k++) begin
            exp_q.push_back({model_ptr, rb[k]});
            model_ptr = model_ptr + 8'd1;
          end
        end
      end
      wait_clk(2);
      check_writes($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d idle", t), 32'(state), 32'(T_IDLE));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_fsm.md
Name: i2c_slave_fsm

Overview:
- Protocol controller for the chip's I2C slave port.
- Detects START/STOP, counts bits, checks the device address, captures the register pointer and write data, and sequences the state/index bus consumed by the SCL-falling-edge pin-driver block.
- Sits between the raw SCL/SDA input pads and the PID register file.
- Provides a register write strobe and fetches read data for the single-byte read path.

Parameters:
DEVICE_ADDR, 7'h2A, 7-bit slave address matched during the address phase
SYNC_STAGES, 2, flops in the SCL/SDA input synchronisers (min 2)

Ports:
clk  input  1  system clock; SCL/SDA are oversampled (clk at least 8x SCL)
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state (synchronisers included)
SCL_in  input  1  raw SCL pad input
SDA_in  input  1  raw SDA pad input
state  output  5  current protocol state (encoding below) to the pin driver
data_index  output  3  bit index of the byte in flight, MSB first (7..0)
read_value  output  8  byte being shifted out in READ
reg_addr  output  8  register pointer; also the read address to the register file
reg_rd_data  input  8  register file read data for reg_addr (combinational)
reg_wr_data  output  8  assembled write byte
reg_wr_en  output  1  one-clk write strobe
busy  output  1  high in any state other than IDLE

Behaviour:
- State encoding (shared package): IDLE 0, START 1, DEVICE_ADDR 2, READ_OR_WRITE 3, ADDR_ACK 4, REG_ADDR 5, REG_ACK 6, WRITE 7, WRITE_ACK 8, READ 9, READ_ACK 10, STOP 11. Codes 12-31 are illegal and go to IDLE on the next clk.
- Reset (async assert, sync release): state=IDLE, data_index=7, all other outputs 0, rw flag 0, synchronisers cleared to 1 (bus idle).
- Event detection on synchronised signals, one clk after the synchronised change:
  - rise = SCL 0->1; fall = SCL 1->0.
  - START = SDA 1->0 while SCL high.
  - STOP = SDA 0->1 while SCL high.
- Priority: STOP > START > SCL edges.
  - STOP in any state -> IDLE.
  - START in any state, including a repeated start, -> START with data_index=7.
- Bits are sampled on rise. State changes on rise, so the pin driver sees the new state at the following fall.
- Transitions:
  - START --fall--> DEVICE_ADDR, data_index=6.
  - DEVICE_ADDR: each rise shifts SDA into the address register. data_index 6..0 decrements; after index 0 -> READ_OR_WRITE.
  - READ_OR_WRITE --rise--> latch rw=SDA. If the address matches -> ADDR_ACK; otherwise -> IDLE, ignoring the bus until the next START.
  - ADDR_ACK --rise--> REG_ADDR (rw=0) or READ (rw=1). On entry to READ: read_value=reg_rd_data, data_index=7.
  - REG_ADDR: 8 rises shift into reg_addr, MSB first -> REG_ACK.
  - REG_ACK --rise--> WRITE, data_index=7.
  - WRITE: 8 rises shift into reg_wr_data -> WRITE_ACK. reg_wr_en pulses for exactly one clk on the cycle of entry.
  - WRITE_ACK --rise--> WRITE. reg_addr increments, wrapping 8'hFF->8'h00.
  - READ: each rise decrements data_index; after index 0 -> READ_ACK. read_value is held for the whole byte.
  - READ_ACK --rise--> STOP. Reads are single-byte per addressed transaction.
  - STOP: waits for the STOP or START condition.
- Edge cases:
  - reg_wr_en never asserts for a partial byte. A STOP or START mid-byte discards the bits.
  - ena low: no events are detected and outputs hold. On re-enable the synchronisers restart from their held values with no spurious edge.
  - Reset mid-transaction: IDLE immediately, and no reg_wr_en is generated.

Decomposition:
- Package i2c_pkg: state localparams (IDLE..STOP), STATE_W=5, DATA_W=8.
- Sub-module i2c_edge_detect: synchronisers plus rise/fall/START/STOP pulse generation, instantiated once; FSM and datapath in the top.

Test Plan:
- Write 0x2A/W, reg 0x10, data 0x5C, STOP -> ADDR_ACK and REG_ACK reached; one reg_wr_en with reg_wr_data=0x5C, reg_addr=0x10; then IDLE.
- Burst write reg 0xFF, data 0x11, 0x22 -> writes to 0xFF then 0x00 (wrap); two strobes.
- Write reg 0x03, repeated START, 0x2A/R, reg_rd_data=0xA5 -> READ with read_value=0xA5, data_index steps 7..0; READ_ACK; STOP state; IDLE after STOP.
- Address 0x2B/W -> IDLE after READ_OR_WRITE; no ADDR_ACK and no strobe for the following bytes.
- STOP after 4 data bits of WRITE -> IDLE, no reg_wr_en; also async reset mid-REG_ADDR -> all outputs at reset values within one clk.
- ena low for 20 clk mid-DEVICE_ADDR while SCL toggles -> state/data_index frozen; resumes without phantom edge on re-enable.
